pc_gen_unit: RTL and testbench

Registered program-counter generator for the RISC-V core; the successor of the plain next-PC selector.
- Holds the fetch PC and selects the next PC from sequential, branch/JAL, JALR and trap-return sources.
- Adds stall handling and capture of redirects that arrive during a stall.
- Detects misaligned targets and raises them as traps, vectoring to a trap address and saving the faulting PC in an EPC register.
- Sits between the control unit/ALU and instruction memory.

---
 rtl/pc_gen_unit_pkg.sv | 24 ++
 rtl/pc_gen_unit_if.sv | 28 ++
 rtl/pc_gen_unit_target_mux.sv | 33 +++
 rtl/pc_gen_unit.sv | 109 ++++++++++
 tb/tb_pc_gen_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_unit_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_pkg;

    // Next-PC source encoding as presented on pc_src_i
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_TRET   = 2'b11
    } pc_src_e;

    // Sequencer states of the PC generator
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pcgen_state_e;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int          INSTR_BYTES_DEF  = 4;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Control/fetch-side bus of the PC generator.
interface pc_gen_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic [1:0]      pc_src_i;
    logic [XLEN-1:0] branch_target_i;
    logic [XLEN-1:0] jalr_target_i;
    logic            trap_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic [XLEN-1:0] epc_o;
    logic            misalign_o;
    logic            redirect_pending_o;
    logic            fetch_valid_o;

    // Control unit / hazard logic side
    modport master (
        output stall_i, pc_src_i, branch_target_i, jalr_target_i, trap_i,
        input  pc_o, pc_plus4_o, epc_o, misalign_o, redirect_pending_o, fetch_valid_o
    );

    // PC generator side
    modport slave (
        input  stall_i, pc_src_i, branch_target_i, jalr_target_i, trap_i,
        output pc_o, pc_plus4_o, epc_o, misalign_o, redirect_pending_o, fetch_valid_o
    );
endinterface

// File: rtl/pc_gen_unit_target_mux.sv
// Candidate next-PC selection with JALR bit-0 clearing and alignment check.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic [1:0]      pc_src_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    pc_src_e src;
    assign src = pc_src_e'(pc_src_i);

    // Pick the candidate and flag misaligned branch/JALR targets only
    always_comb begin
        target_o = pc_i + XLEN'(INSTR_BYTES);
        case (src)
            PC_SEQ:    target_o = pc_i + XLEN'(INSTR_BYTES);
            PC_BRANCH: target_o = branch_target_i;
            PC_JALR:   target_o = {jalr_target_i[XLEN-1:1], 1'b0};
            PC_TRET:   target_o = epc_i;
            default:   target_o = pc_i + XLEN'(INSTR_BYTES);
        endcase
        misalign_o = ((src == PC_BRANCH) || (src == PC_JALR)) && (|(target_o & ALIGN_MASK));
    end
endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch-PC generator: BOOT/RUN/HOLD sequencing, stall-time
// redirect capture, misaligned-target traps and EPC save.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pc_gen_unit_if.slave pc_if
);
    localparam logic [1:0] ST_BOOT = 2'(BOOT);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] cand;
    logic            cand_misalign;

    pc_target_mux #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_mux (
        .pc_src_i        (pc_if.pc_src_i),
        .pc_i            (pc_q),
        .branch_target_i (pc_if.branch_target_i),
        .jalr_target_i   (pc_if.jalr_target_i),
        .epc_i           (epc_q),
        .target_o        (cand),
        .misalign_o      (cand_misalign)
    );

    // Next-state: trap beats misalignment beats stall; HOLD waits for release
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        misalign_d   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (pc_if.trap_i) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (cand_misalign) begin
                    pc_d       = TRAP_VECTOR;
                    epc_d      = pc_q;
                    misalign_d = 1'b1;
                end else if (pc_if.stall_i && (pc_if.pc_src_i != 2'(PC_SEQ))) begin
                    pend_d       = cand;
                    pend_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (!pc_if.stall_i) begin
                    pc_d = cand;
                end
            end
            ST_HOLD: begin
                if (pc_if.trap_i) begin
                    pc_d         = TRAP_VECTOR;
                    epc_d        = pc_q;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end else if (!pc_if.stall_i) begin
                    pc_d         = pend_q;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers; reset also drops any captured redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_if.pc_o               = pc_q;
    assign pc_if.pc_plus4_o         = pc_q + XLEN'(INSTR_BYTES);
    assign pc_if.epc_o              = epc_q;
    assign pc_if.misalign_o         = misalign_q;
    assign pc_if.redirect_pending_o = pend_valid_q;
    assign pc_if.fetch_valid_o      = (state_q == ST_RUN) && !pc_if.stall_i;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus random traffic
// against a behavioural next-PC model.
module tb_pc_gen_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    pc_gen_unit_if #(.XLEN(32)) bus ();

    pc_gen_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .INSTR_BYTES  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pc_if (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain program-counter semantics
    bit [31:0] m_pc, m_epc, m_pend;
    bit        m_pend_v, m_mis, m_booting, m_holding;

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_pend = 32'h0;
        m_pend_v = 0; m_mis = 0; m_booting = 1; m_holding = 0;
    endtask

    task automatic model_step();
        bit [31:0] tgt;
        bit bad;
        m_mis = 0;
        if (m_booting) begin
            m_booting = 0;
        end else if (m_holding) begin
            if (bus.trap_i) begin
                m_epc = m_pc; m_pc = 32'h100; m_pend_v = 0; m_holding = 0;
            end else if (!bus.stall_i) begin
                m_pc = m_pend; m_pend_v = 0; m_holding = 0;
            end
        end else begin
            case (bus.pc_src_i)
                2'd0: tgt = m_pc + 32'd4;
                2'd1: tgt = bus.branch_target_i;
                2'd2: tgt = bus.jalr_target_i - (bus.jalr_target_i % 2);
                default: tgt = m_epc;
            endcase
            bad = (bus.pc_src_i == 2'd1 || bus.pc_src_i == 2'd2) && (tgt % 4 != 0);
            if (bus.trap_i) begin
                m_epc = m_pc; m_pc = 32'h100;
            end else if (bad) begin
                m_epc = m_pc; m_pc = 32'h100; m_mis = 1;
            end else if (bus.stall_i) begin
                if (bus.pc_src_i != 2'd0) begin
                    m_pend = tgt; m_pend_v = 1; m_holding = 1;
                end
            end else begin
                m_pc = tgt;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit st, input bit [1:0] src, input bit [31:0] bt,
                          input bit [31:0] jt, input bit tr);
        bus.stall_i = st; bus.pc_src_i = src; bus.branch_target_i = bt;
        bus.jalr_target_i = jt; bus.trap_i = tr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 2'd0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 2'd0, 0, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (bus.pc_o !== 32'h0 || bus.fetch_valid_o !== 1'b0 || bus.epc_o !== 32'h0 ||
            bus.misalign_o !== 1'b0 || bus.redirect_pending_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state pc=%h fv=%b epc=%h mis=%b pend=%b, want 0/0/0/0/0",
                     bus.pc_o, bus.fetch_valid_o, bus.epc_o, bus.misalign_o, bus.redirect_pending_o);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.pc_o !== 32'h0 || bus.fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL boot_cycle pc=%h fv=%b, want 0 fv=0", bus.pc_o, bus.fetch_valid_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.pc_o !== 32'(4 * i) || bus.fetch_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL seq_%0d pc=%h fv=%b, want %h fv=1", i, bus.pc_o, bus.fetch_valid_o, 4 * i);
            end
            tick();
        end
    endtask

    task automatic test_jalr();
        set_in(0, 2'd2, 0, 32'h0000_1001, 0);
        tick();
        checks++;
        if (bus.pc_o !== 32'h1000 || bus.misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL jalr_clear pc=%h mis=%b, want 00001000 mis=0", bus.pc_o, bus.misalign_o);
        end
        set_in(0, 2'd2, 0, 32'h0000_1002, 0);
        tick();
        checks++;
        if (bus.pc_o !== 32'h100 || bus.epc_o !== 32'h1000 || bus.misalign_o !== 1'b1) begin
            failures++;
            $display("FAIL jalr_misalign pc=%h epc=%h mis=%b, want 100/1000/1",
                     bus.pc_o, bus.epc_o, bus.misalign_o);
        end
        set_in(0, 2'd0, 0, 0, 0);
        tick();
        checks++;
        if (bus.misalign_o !== 1'b0 || bus.pc_o !== 32'h104) begin
            failures++;
            $display("FAIL misalign_pulse pc=%h mis=%b, want 104 mis=0", bus.pc_o, bus.misalign_o);
        end
    endtask

    task automatic test_stall_capture();
        bit [31:0] p0;
        p0 = bus.pc_o;
        set_in(1, 2'd1, 32'h200, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.fetch_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_fv_%0d fv=%b, want 0", i, bus.fetch_valid_o);
            end
            tick();
            checks++;
            if (bus.redirect_pending_o !== 1'b1 || bus.pc_o !== p0) begin
                failures++;
                $display("FAIL stall_hold_%0d pend=%b pc=%h, want 1 %h", i, bus.redirect_pending_o, bus.pc_o, p0);
            end
        end
        set_in(0, 2'd0, 0, 0, 0);
        tick();
        checks++;
        if (bus.pc_o !== 32'h200 || bus.redirect_pending_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_release pc=%h pend=%b, want 200 0", bus.pc_o, bus.redirect_pending_o);
        end
    endtask

    task automatic test_trap_hold();
        set_in(0, 2'd1, 32'h40, 0, 0);
        tick();
        set_in(1, 2'd1, 32'h200, 0, 0);
        tick();
        set_in(1, 2'd0, 0, 0, 1);
        tick();
        checks++;
        if (bus.pc_o !== 32'h100 || bus.epc_o !== 32'h40 || bus.redirect_pending_o !== 1'b0) begin
            failures++;
            $display("FAIL trap_in_hold pc=%h epc=%h pend=%b, want 100 40 0",
                     bus.pc_o, bus.epc_o, bus.redirect_pending_o);
        end
        set_in(0, 2'd3, 0, 0, 0);
        tick();
        checks++;
        if (bus.pc_o !== 32'h40) begin
            failures++;
            $display("FAIL trap_return pc=%h, want 00000040", bus.pc_o);
        end
    endtask

    task automatic test_wrap_priority();
        set_in(0, 2'd1, 32'hFFFF_FFFC, 0, 0);
        tick();
        checks++;
        if (bus.pc_plus4_o !== 32'h0) begin
            failures++;
            $display("FAIL plus4_wrap got=%h, want 00000000", bus.pc_plus4_o);
        end
        set_in(0, 2'd0, 0, 0, 0);
        tick();
        checks++;
        if (bus.pc_o !== 32'h0 || bus.misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL seq_wrap pc=%h mis=%b, want 0 0", bus.pc_o, bus.misalign_o);
        end
        set_in(0, 2'd1, 32'h202, 0, 1);
        tick();
        checks++;
        if (bus.pc_o !== 32'h100 || bus.misalign_o !== 1'b0 || bus.epc_o !== 32'h0) begin
            failures++;
            $display("FAIL trap_beats_misalign pc=%h mis=%b epc=%h, want 100 0 0",
                     bus.pc_o, bus.misalign_o, bus.epc_o);
        end
        set_in(0, 2'd0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        set_in(1, 2'd1, 32'h300, 0, 0);
        tick();
        checks++;
        if (bus.redirect_pending_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_entry pend=%b, want 1", bus.redirect_pending_o);
        end
        set_in(0, 2'd0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.pc_o !== 32'h0 || bus.redirect_pending_o !== 1'b0 || bus.fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pc=%h pend=%b fv=%b, want 0 0 0",
                     bus.pc_o, bus.redirect_pending_o, bus.fetch_valid_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reboot_boot fv=%b, want 0", bus.fetch_valid_o);
        end
        tick();
        checks++;
        if (bus.fetch_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.redirect_pending_o !== 1'b0) begin
            failures++;
            $display("FAIL reboot_run fv=%b pc=%h pend=%b, want 1 0 0",
                     bus.fetch_valid_o, bus.pc_o, bus.redirect_pending_o);
        end
    endtask

    task automatic test_random();
        int errs_here;
        errs_here = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit [31:0] bt, jt;
            bt = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 7) == 0) bt = bt | 32'($urandom_range(1, 3));
            jt = $urandom & 32'h0000_FFFD;
            if ($urandom_range(0, 7) == 0) jt = jt | 32'h2;
            set_in($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), bt, jt,
                   $urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (bus.fetch_valid_o !== (!m_booting && !m_holding && !bus.stall_i)) begin
                failures++;
                if (errs_here++ < 10) $display("FAIL rand_fv cyc=%0d got=%b", i, bus.fetch_valid_o);
            end
            tick();
            checks++;
            if (bus.pc_o !== m_pc || bus.epc_o !== m_epc || bus.misalign_o !== m_mis ||
                bus.redirect_pending_o !== m_pend_v || bus.pc_plus4_o !== m_pc + 32'd4) begin
                failures++;
                if (errs_here++ < 10)
                    $display("FAIL rand_state cyc=%0d pc=%h/%h epc=%h/%h mis=%b/%b pend=%b/%b p4=%h",
                             i, bus.pc_o, m_pc, bus.epc_o, m_epc, bus.misalign_o, m_mis,
                             bus.redirect_pending_o, m_pend_v, bus.pc_plus4_o);
            end
        end
    endtask

    initial begin
        set_in(0, 2'd0, 0, 0, 0);
        model_reset();
        test_reset();
        test_jalr();
        test_stall_capture();
        test_trap_hold();
        test_wrap_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
